// File: rtl/data_memory_responder.sv
// Multi-cycle data memory for the MEM stage: holds the pipeline with stall for
// WAIT_STATES extra cycles per access and rejects misaligned or read+write requests.
module data_memory_responder #(
    parameter int WAIT_STATES = 2,
    parameter int ADDR_BITS   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        mem_error
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_err;
    logic                 r_is_write;
    logic [ADDR_BITS-1:0] r_idx;
    logic [31:0]          r_wdata;
    logic [31:0]          r_read_data;
    logic [31:0]          r_mem [0:DEPTH-1];

    logic w_req;
    logic w_bad;
    logic w_last;
    logic w_wr_en;
    logic w_unused_addr;

    assign w_req   = MemRead | MemWrite;
    assign w_bad   = (address[1:0] != 2'b00) | (MemRead & MemWrite);
    assign w_last  = (r_state == S_ACCESS) & w_req & (r_cnt == '0);
    // Gating with reset keeps a write pending at reset assertion from committing.
    assign w_wr_en = reset & w_last & r_is_write;
    // Upper address bits are deliberately dropped so addresses wrap modulo depth.
    assign w_unused_addr = ^address[31:ADDR_BITS+2];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_err       <= 1'b0;
            r_is_write  <= 1'b0;
            r_idx       <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx      <= address[ADDR_BITS+1:2];
                        r_wdata    <= write_data;
                        r_is_write <= MemWrite;
                        r_err      <= w_bad;
                        r_cnt      <= CNT_INIT;
                        r_state    <= w_bad ? S_DONE : S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= S_DONE;
                        if (!r_is_write) begin
                            r_read_data <= r_mem[r_idx];
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign read_data = r_read_data;
    assign stall     = reset & w_req & (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign mem_error = (r_state == S_DONE) & r_err;

endmodule

// File: tb/tb_data_memory_responder.sv
// Randomized bench for data_memory_responder: a transaction-level timing and
// memory model predicts stall/done/mem_error/read_data every cycle.
module tb_data_memory_responder;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [31:0] address = '0, write_data = '0;
    logic [31:0] read_data;
    logic        stall, done, mem_error;

    logic        r0 = 1'b0, w0 = 1'b0;
    logic [31:0] a0 = '0, wd0 = '0;
    logic [31:0] rd0;
    logic        stall0, done0, err0;

    data_memory_responder #(.WAIT_STATES(W), .ADDR_BITS(8)) dut (
        .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
        .address(address), .write_data(write_data), .read_data(read_data),
        .stall(stall), .done(done), .mem_error(mem_error)
    );

    data_memory_responder #(.WAIT_STATES(0), .ADDR_BITS(8)) dut0 (
        .clk(clk), .reset(reset), .MemRead(r0), .MemWrite(w0),
        .address(a0), .write_data(wd0), .read_data(rd0),
        .stall(stall0), .done(done0), .mem_error(err0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_mem [256];
    logic [31:0] model_rd = '0;
    logic        exp_stall = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
    logic        chk_en = 1'b0;
    int          stall_run = 0;
    int          last_stall_len = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic set_exp(input logic s, input logic d, input logic e);
        exp_stall = s;
        exp_done  = d;
        exp_err   = e;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall", {31'b0, stall}, {31'b0, exp_stall});
            chk("done", {31'b0, done}, {31'b0, exp_done});
            chk("mem_error", {31'b0, mem_error}, {31'b0, exp_err});
            chk("read_data", read_data, model_rd);
        end
        if (stall === 1'b1) stall_run++;
        else if (done === 1'b1) begin
            last_stall_len = stall_run;
            stall_run = 0;
        end else stall_run = 0;
    end

    // One request on the W=2 instance; flush_at in 1..W+1 drops the request in that cycle.
    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int flush_at);
        bit legal;
        int idx;
        legal = (a[1:0] == 2'b00) && !(rd && wr);
        idx   = int'(a[9:2]);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; address = a; write_data = wd;
        set_exp(1'b1, 1'b0, 1'b0);
        if (!legal) begin
            @(posedge clk); #1;
            address = $urandom; write_data = $urandom;
            set_exp(1'b0, 1'b1, 1'b1);
            return;
        end
        for (int c = 1; c <= W + 1; c++) begin
            @(posedge clk); #1;
            address = $urandom; write_data = $urandom;
            if (c == flush_at) begin
                MemRead = 1'b0; MemWrite = 1'b0;
                set_exp(1'b0, 1'b0, 1'b0);
                return;
            end
            set_exp(1'b1, 1'b0, 1'b0);
        end
        @(posedge clk); #1;
        if (wr) model_mem[idx] = wd;
        else    model_rd = model_mem[idx];
        set_exp(1'b0, 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            MemRead = 1'b0; MemWrite = 1'b0;
            set_exp(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    // One request on the W=0 instance: stall for cycles 0-1, done in cycle 2.
    task automatic req0(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            r0 = rd; w0 = wr; a0 = a; wd0 = wd;
            @(negedge clk);
            chk("w0_stall", {31'b0, stall0}, (c < 2) ? 32'd1 : 32'd0);
            chk("w0_done", {31'b0, done0}, (c == 2) ? 32'd1 : 32'd0);
        end
        chk("w0_read_data", rd0, exp_rd);
        chk("w0_mem_error", {31'b0, err0}, 32'd0);
        @(posedge clk); #1;
        r0 = 1'b0; w0 = 1'b0;
    endtask

    initial begin
        int gap, fl, kind;
        bit rd, wr;
        logic [31:0] a;
        #1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;

        // Fill the whole array so every later read has a known model value.
        for (int i = 0; i < 256; i++) begin
            a = {$urandom_range(0, 4194303), 10'b0} | (i << 2);
            do_req(1'b0, 1'b1, a, $urandom, 0);
        end
        idle(1);

        do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 0);
        settle();
        chk("wr_stall_len", last_stall_len, 32'd4);
        chk("wr_no_err", {31'b0, mem_error}, 32'd0);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 0);
        settle();
        chk("raw_read", read_data, 32'hDEADBEEF);
        idle(2);
        chk("read_held", read_data, 32'hDEADBEEF);

        do_req(1'b1, 1'b0, 32'h13, 32'h0, 0);
        settle();
        chk("err_stall_len", last_stall_len, 32'd1);
        chk("err_flag", {31'b0, mem_error}, 32'd1);
        chk("err_rd_keep", read_data, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 32'h10, 32'h0, 0);
        settle();
        chk("err_arr_keep", read_data, 32'hDEADBEEF);

        do_req(1'b0, 1'b1, 32'h400, 32'h1, 0);
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 0);
        settle();
        chk("wrap_read", read_data, 32'h1);
        do_req(1'b1, 1'b1, 32'h0, 32'h77, 0);
        settle();
        chk("rw_both_err", {31'b0, mem_error}, 32'd1);
        do_req(1'b1, 1'b0, 32'h0, 32'h0, 0);
        settle();
        chk("rw_both_nowrite", read_data, 32'h1);

        do_req(1'b0, 1'b1, 32'h40, 32'hAAAA5555, 0);
        do_req(1'b0, 1'b1, 32'h40, 32'h12345678, 2);
        idle(1);
        do_req(1'b1, 1'b0, 32'h40, 32'h0, 0);
        settle();
        chk("flush_old", read_data, 32'hAAAA5555);

        // Reset during the ACCESS of a write: outputs cleared at once, write discarded.
        do_req(1'b0, 1'b1, 32'h80, 32'h11112222, 0);
        @(posedge clk); #1;
        MemWrite = 1'b1; address = 32'h80; write_data = 32'h99998888;
        set_exp(1'b1, 1'b0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        model_rd = '0;
        set_exp(1'b0, 1'b0, 1'b0);
        #1 chk("rst_rd_now", read_data, 32'h0);
        chk("rst_stall_now", {31'b0, stall}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1; MemWrite = 1'b0;
        do_req(1'b1, 1'b0, 32'h80, 32'h0, 0);
        settle();
        chk("rst_no_write", read_data, 32'h11112222);

        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            rd = (kind < 5) || (kind == 9);
            wr = (kind >= 5);
            a = $urandom;
            if ($urandom_range(0, 7) != 0) a[1:0] = 2'b00;
            fl = ($urandom_range(0, 7) == 0) ? $urandom_range(1, W + 1) : 0;
            do_req(rd, wr, a, $urandom, fl);
            gap = $urandom_range(0, 2);
            if (fl != 0 && gap == 0) gap = 1;
            idle(gap);
        end
        idle(2);

        req0(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 32'h0);
        req0(1'b1, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/data_memory_responder.md
# data_memory_responder

Multi-cycle data memory for the pipelined CPU's MEM stage. It accepts the MemRead/MemWrite request driven by the memory stage, inserts a configurable number of wait states, and holds the pipeline with `stall` until the access completes. It also flags illegal requests (misaligned address, simultaneous read and write) without touching the array.

## Interface
- `WAIT_STATES`, default 2: extra access cycles per request (0 allowed).
- `ADDR_BITS`, default 8: word-index width; depth is 2^ADDR_BITS 32-bit words.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `MemRead` input, 1 bit: read request, held by the pipeline while `stall` is high.
- `MemWrite` input, 1 bit: write request, held by the pipeline while `stall` is high.
- `address` input, 32 bits: byte address, taken from the ALU result.
- `write_data` input, 32 bits: store data.
- `read_data` output, 32 bits: registered load data, held until the next completed read.
- `stall` output, 1 bit: freeze the PC and the pipeline registers.
- `done` output, 1 bit: one-cycle completion pulse.
- `mem_error` output, 1 bit: completion pulse for a rejected request.

## Operation
- States: IDLE, ACCESS, DONE.
- Request: `req = MemRead | MemWrite`.
- IDLE with `req`:
  - Latch `address`, `write_data` and the request type.
  - If `address[1:0] != 0`, or both `MemRead` and `MemWrite` are high, go to DONE with the error flag set.
  - Otherwise go to ACCESS with `cnt = WAIT_STATES`.
- IDLE without `req`: stay in IDLE.
- ACCESS, `req` still high, `cnt != 0`: decrement `cnt`.
- ACCESS, `req` still high, `cnt == 0`: perform the access and go to DONE.
  - Read: `read_data <= mem[idx]`.
  - Write: `mem[idx] <= latched write_data`.
- ACCESS, `req` low (flush): abort, go to IDLE, no write, `read_data` unchanged, no `done`.
- DONE: always returns to IDLE on the next edge. On the following cycle the pipeline presents the next request.
- Word index `idx = latched address[ADDR_BITS+1:2]`. Upper address bits are ignored, so addresses wrap modulo depth.
- Changes to `address` or `write_data` after acceptance are ignored.
- Error completion: no array access, `read_data` unchanged.
- Combinational outputs:
  - `stall = reset & req & (state != DONE)`
  - `done = (state == DONE)`
  - `mem_error = (state == DONE) & err_flag`
- Array contents are not reset. All state, `cnt`, `err_flag` and `read_data` are reset.

## Timing
- Reset values: state IDLE, `read_data` 0, `cnt` 0, `stall` 0, `done` 0, `mem_error` 0. `stall` is forced to 0 while `reset` is low.
- Reset asserted mid-access: immediate return to IDLE. A pending write is discarded; `read_data` becomes 0.
- Legal request first seen at cycle 0 (IDLE):
  - `stall` is high in cycles 0 through W+1, where W = `WAIT_STATES`.
  - ACCESS occupies cycles 1 through W+1.
  - The array access happens at the edge that ends cycle W+1.
  - DONE is cycle W+2: `stall` 0, `done` 1, `read_data` valid.
- Pipeline registers advance at the edge ending DONE.
- Error request: `stall` is high for cycle 0 only. Cycle 1 is DONE with `done`=1 and `mem_error`=1.
- No request: `stall` stays 0, zero overhead.
- Back-to-back requests: the second is accepted in the cycle after DONE, so there is no bubble beyond the wait states.
- Read-after-write to the same word returns the new data, because the write commits before the read's ACCESS.

## Test plan
- Reset, then W=2, write 0xDEADBEEF to address 0x10 -> `stall` high for 4 cycles, `done` in cycle 4, `mem_error` 0.
- Read address 0x10 immediately after that write -> `read_data` = 0xDEADBEEF in the DONE cycle, held afterwards until the next read.
- Read address 0x13 -> `stall` for 1 cycle, then `done`=1 and `mem_error`=1; `read_data` unchanged and the array unchanged.
- With ADDR_BITS=8, write 0x1 to address 0x400 then read address 0x0 -> 0x1 (wrap). Also drive MemRead and MemWrite together -> `mem_error`=1 and no write.
- Drop MemWrite during ACCESS (flush) -> return to IDLE, no `done`, and a later read of that word returns the old value.
- Pulse `reset` low during ACCESS of a write -> outputs go to their reset values immediately, no write occurs. With W=0 -> `stall` lasts 2 cycles per legal request.
